// File: rtl/regwb_scoreboard.sv
// regwb_scoreboard: write-back controller and hazard scoreboard for the
// 32x32 RV32 register file (one write port, two async read ports).
//
// Two producers share the single write port: the ALU (never back-pressured)
// and the long-latency LSU/multiplier (valid/ready). A one-entry hold buffer
// absorbs an ALU result that loses arbitration. A pending bitmap tracks
// outstanding destinations and stalls issue on RAW/WAW hazards. Only one
// long op may be outstanding.
//
// Ports:
//   Clock, nReset                - clock (rising edge), async active-low reset
//   issue_*                      - decode issue request; issue_stall (comb)
//   alu_valid/rd/data            - ALU result, accepted unconditionally
//   lsu_valid/rd/data, lsu_ready - LSU result handshake (lsu_ready comb)
//   writeRegMem, rd, dataIn      - registered register-file write port
//   busy_mask                    - registered pending-write bitmap
module regwb_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic            issue_uses_rs1,
  input  logic            issue_uses_rs2,
  input  logic            issue_long,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            writeRegMem,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] dataIn,
  output logic [NREG-1:0] busy_mask
);

  logic [NREG-1:0] pending_q, pending_d, set_vec, clr_vec;
  logic            long_busy_q, long_busy_d;
  logic            hold_vld_q, hold_vld_d;
  logic [4:0]      hold_rd_q, hold_rd_d;
  logic [XLEN-1:0] hold_data_q, hold_data_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_rd_q, wr_rd_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  logic            raw1, raw2, waw, long_hz, issue_acc, lsu_hs;
  logic            win_vld;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  // ---------------- hazard detection ----------------
  // pending_q[0] is held at 0, so x0 sources/destinations never stall.
  assign raw1        = issue_uses_rs1 && pending_q[issue_rs1];
  assign raw2        = issue_uses_rs2 && pending_q[issue_rs2];
  assign waw         = (issue_rd != 5'd0) && pending_q[issue_rd];
  assign long_hz     = issue_long && long_busy_q;
  assign issue_stall = issue_valid && (raw1 || raw2 || waw || long_hz);
  assign issue_acc   = issue_valid && !issue_stall;

  assign lsu_ready   = !hold_vld_q;
  assign lsu_hs      = lsu_valid && lsu_ready;

  // ---------------- write-port arbitration ----------------
  // Priority: hold buffer > LSU > ALU. Whenever the ALU loses, its result
  // lands in the hold buffer; the buffer drains every cycle it is full, so a
  // single entry is enough for one ALU result per cycle.
  always_comb begin
    win_vld     = 1'b0;
    win_rd      = 5'd0;
    win_data    = '0;
    hold_vld_d  = 1'b0;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    if (hold_vld_q || lsu_valid) begin
      win_vld  = 1'b1;
      win_rd   = hold_vld_q ? hold_rd_q   : lsu_rd;
      win_data = hold_vld_q ? hold_data_q : lsu_data;
      if (alu_valid) begin
        hold_vld_d  = 1'b1;
        hold_rd_d   = alu_rd;
        hold_data_d = alu_data;
      end
    end else if (alu_valid) begin
      win_vld  = 1'b1;
      win_rd   = alu_rd;
      win_data = alu_data;
    end
  end

  // A winner targeting x0 is consumed but never written.
  always_comb begin
    wr_en_d   = win_vld && (win_rd != 5'd0);
    wr_rd_d   = win_vld ? win_rd   : wr_rd_q;
    wr_data_d = win_vld ? win_data : wr_data_q;
  end

  // ---------------- scoreboard ----------------
  // Clear wins over set on the same bit; WAW stalls make that case
  // unreachable, but the ordering keeps the bitmap consistent regardless.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_acc && issue_rd != 5'd0) set_vec[issue_rd] = 1'b1;
    if (wr_en_q)                       clr_vec[wr_rd_q]  = 1'b1;
    pending_d    = (pending_q | set_vec) & ~clr_vec;
    pending_d[0] = 1'b0;
  end

  // Issue of a long op is only accepted while no long op is outstanding,
  // so a same-cycle handshake and new long issue leave the flag set.
  always_comb begin
    long_busy_d = long_busy_q;
    if (lsu_hs)                   long_busy_d = 1'b0;
    if (issue_acc && issue_long)  long_busy_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pending_q   <= '0;
      long_busy_q <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_rd_q   <= 5'd0;
      hold_data_q <= '0;
      wr_en_q     <= 1'b0;
      wr_rd_q     <= 5'd0;
      wr_data_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      long_busy_q <= long_busy_d;
      hold_vld_q  <= hold_vld_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
      wr_en_q     <= wr_en_d;
      wr_rd_q     <= wr_rd_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign writeRegMem = wr_en_q;
  assign rd          = wr_rd_q;
  assign dataIn      = wr_data_q;
  assign busy_mask   = pending_q;

endmodule

// File: tb/tb_regwb_scoreboard.sv
// Bench for regwb_scoreboard: directed stimulus pushes expected register-file
// writes into a queue in the order they must appear; a monitor pops and
// compares on every writeRegMem cycle. Combinational/state checks are done
// inline by the stimulus.
module tb_regwb_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic            Clock = 1'b0;
  logic            nReset;
  logic            issue_valid, issue_uses_rs1, issue_uses_rs2, issue_long;
  logic [4:0]      issue_rd, issue_rs1, issue_rs2;
  logic            issue_stall;
  logic            alu_valid, lsu_valid, lsu_ready;
  logic [4:0]      alu_rd, lsu_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic            writeRegMem;
  logic [4:0]      rd;
  logic [XLEN-1:0] dataIn;
  logic [NREG-1:0] busy_mask;

  regwb_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
    .Clock(Clock), .nReset(nReset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_uses_rs1(issue_uses_rs1),
    .issue_uses_rs2(issue_uses_rs2), .issue_long(issue_long),
    .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_ready(lsu_ready),
    .writeRegMem(writeRegMem), .rd(rd), .dataIn(dataIn),
    .busy_mask(busy_mask)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [XLEN-1:0] d);
    exp_t e;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write must match the next expected write, in order.
  always @(negedge Clock) begin : mon
    exp_t e;
    if (nReset === 1'b1 && writeRegMem === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", rd, dataIn);
      end else begin
        e = exp_q.pop_front();
        if (rd !== e.rd || dataIn !== e.data) begin
          n_miss++;
          $display("FAIL write_port: got rd=%0d data=%h, expected rd=%0d data=%h",
                   rd, dataIn, e.rd, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_long = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic iss(input logic [4:0] d, input logic [4:0] s1, input logic u1, input logic lng);
    issue_valid = 1; issue_rd = d; issue_rs1 = s1; issue_uses_rs1 = u1;
    issue_rs2 = 0; issue_uses_rs2 = 0; issue_long = lng;
  endtask

  initial begin
    idle();
    nReset = 0;
    repeat (2) tick();
    nReset = 1;
    #1;
    chk("reset_wr",    {63'd0, writeRegMem}, 64'd0);
    chk("reset_busy",  {32'd0, busy_mask},   64'd0);
    chk("reset_ready", {63'd0, lsu_ready},   64'd1);

    // ---- reset mid-stream: pending=0xF00, hold buffer occupied ----
    for (int i = 8; i < 12; i++) begin
      tick(); idle(); iss(5'(i), 5'd0, 1'b0, 1'b0);
      #1 chk("fill_stall", {63'd0, issue_stall}, 64'd0);
    end
    tick(); idle();
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC;
    alu_valid = 1; alu_rd = 13; alu_data = 32'hD;
    push(5'd12, 32'hC);       // x13 sits in the hold buffer and is discarded
    #1 chk("pre_rst_busy", {32'd0, busy_mask}, 64'h0F00);
    tick(); idle();
    #1 chk("pre_rst_ready", {63'd0, lsu_ready}, 64'd0);
    #1 nReset = 0;
    #1;
    chk("rst_wr",    {63'd0, writeRegMem}, 64'd0);
    chk("rst_rd",    {59'd0, rd},          64'd0);
    chk("rst_data",  {32'd0, dataIn},      64'd0);
    chk("rst_busy",  {32'd0, busy_mask},   64'd0);
    chk("rst_ready", {63'd0, lsu_ready},   64'd1);
    tick(); nReset = 1;
    tick(); idle(); iss(5'd0, 5'd9, 1'b1, 1'b0); issue_rs2 = 10; issue_uses_rs2 = 1;
    #1 chk("post_rst_stall", {63'd0, issue_stall}, 64'd0);

    // ---- RAW on x5 through an ALU write ----
    tick(); idle(); iss(5'd5, 5'd0, 1'b0, 1'b0);
    #1 chk("b_issue5", {63'd0, issue_stall}, 64'd0);
    tick(); idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'h1234; push(5'd5, 32'h1234);
    #1 chk("b_busy5_set", {32'd0, busy_mask}, 64'h20);
    tick(); idle(); iss(5'd0, 5'd5, 1'b1, 1'b0);
    #1 chk("b_raw_stall", {63'd0, issue_stall}, 64'd1);
    chk("b_wr", {63'd0, writeRegMem}, 64'd1);
    tick();
    #1 chk("b_raw_go", {63'd0, issue_stall}, 64'd0);
    chk("b_busy5_clr", {32'd0, busy_mask}, 64'd0);

    // ---- LSU and ALU collide ----
    tick(); idle();
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hAAAA;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h5555;
    push(5'd7, 32'hAAAA); push(5'd3, 32'h5555);
    #1 chk("c_ready0", {63'd0, lsu_ready}, 64'd1);
    tick(); idle();
    #1 chk("c_ready1", {63'd0, lsu_ready}, 64'd0);
    tick();
    #1 chk("c_ready2", {63'd0, lsu_ready}, 64'd1);

    // ---- ALU burst while a second LSU result waits ----
    tick(); idle();
    lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h2020;
    alu_valid = 1; alu_rd = 21; alu_data = 32'h21;
    push(5'd20, 32'h2020); push(5'd21, 32'h21);
    tick(); lsu_rd = 25; lsu_data = 32'h2525; alu_rd = 22; alu_data = 32'h22; push(5'd22, 32'h22);
    #1 chk("d_ready1", {63'd0, lsu_ready}, 64'd0);
    tick(); alu_rd = 23; alu_data = 32'h23; push(5'd23, 32'h23);
    #1 chk("d_ready2", {63'd0, lsu_ready}, 64'd0);
    tick(); alu_rd = 24; alu_data = 32'h24; push(5'd24, 32'h24); push(5'd25, 32'h2525);
    #1 chk("d_ready3", {63'd0, lsu_ready}, 64'd0);
    tick(); alu_valid = 0;
    #1 chk("d_ready4", {63'd0, lsu_ready}, 64'd0);
    tick();
    #1 chk("d_ready5", {63'd0, lsu_ready}, 64'd1);
    tick(); idle();

    // ---- long-op serialisation and WAW on x9 ----
    tick(); idle(); iss(5'd9, 5'd0, 1'b0, 1'b1);
    #1 chk("e_long1", {63'd0, issue_stall}, 64'd0);
    tick(); idle(); iss(5'd0, 5'd0, 1'b0, 1'b1);
    #1 chk("e_long2_stall", {63'd0, issue_stall}, 64'd1);
    tick(); idle(); iss(5'd9, 5'd0, 1'b0, 1'b0);
    #1 chk("e_waw_stall", {63'd0, issue_stall}, 64'd1);
    chk("e_busy9", {32'd0, busy_mask}, 64'h200);
    tick(); idle(); iss(5'd0, 5'd0, 1'b0, 1'b1);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h9999; push(5'd9, 32'h9999);
    #1 chk("e_long_hs_cycle", {63'd0, issue_stall}, 64'd1);
    tick(); idle(); iss(5'd9, 5'd0, 1'b0, 1'b0);
    #1 chk("e_waw_during_wr", {63'd0, issue_stall}, 64'd1);
    tick();
    #1 chk("e_waw_go", {63'd0, issue_stall}, 64'd0);
    tick(); idle(); iss(5'd0, 5'd0, 1'b0, 1'b1);
    #1 chk("e_long_go", {63'd0, issue_stall}, 64'd0);
    tick(); idle();
    alu_valid = 1; alu_rd = 9; alu_data = 32'h0909;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h77;
    push(5'd9, 32'h0909);
    tick(); idle();
    #1 chk("e_x0_lsu_nowr", {63'd0, writeRegMem}, 64'd0);
    chk("e_hold_ready", {63'd0, lsu_ready}, 64'd0);
    tick();
    #1 chk("e_hold_wr", {63'd0, writeRegMem}, 64'd1);
    tick(); iss(5'd0, 5'd0, 1'b0, 1'b1);
    #1 chk("e_busy_clr", {32'd0, busy_mask}, 64'd0);
    chk("e_long_clr", {63'd0, issue_stall}, 64'd0);

    // ---- ALU write to x0 ----
    tick(); idle(); alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
    tick(); idle(); iss(5'd0, 5'd0, 1'b1, 1'b0);
    #1 chk("f_x0_nowr", {63'd0, writeRegMem}, 64'd0);
    chk("f_busy0", {32'd0, busy_mask}, 64'd0);
    chk("f_x0_nostall", {63'd0, issue_stall}, 64'd0);

    tick(); idle();
    repeat (3) tick();
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/regwb_scoreboard.md
Name: regwb_scoreboard

Overview:
- Write-back controller and hazard scoreboard for the 32x32 RV32 register file (single write port, two async read ports).
- Arbitrates two producers onto the one write port: the single-cycle ALU and the long-latency LSU/multiplier.
- Tracks pending destination registers and stalls issue on RAW/WAW hazards.
- Drives the register file's writeRegMem/rd/dataIn inputs directly from registered outputs.

Parameters:
XLEN, 32, data width of register file and producers
NREG, 32, number of architectural registers (index width 5)

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous, active-low reset
issue_valid  input  1  decode presents an instruction
issue_rd  input  5  destination register
issue_rs1  input  5  source 1
issue_rs2  input  5  source 2
issue_uses_rs1  input  1  instruction reads rs1
issue_uses_rs2  input  1  instruction reads rs2
issue_long  input  1  instruction goes to the LSU/multiplier
issue_stall  output  1  combinational; issue not accepted this cycle
alu_valid  input  1  ALU result valid; cannot be back-pressured
alu_rd  input  5  ALU result destination
alu_data  input  XLEN  ALU result
lsu_valid  input  1  LSU result valid
lsu_rd  input  5  LSU destination
lsu_data  input  XLEN  LSU result
lsu_ready  output  1  combinational; LSU result accepted when lsu_valid && lsu_ready
writeRegMem  output  1  registered register-file write enable
rd  output  5  registered register-file write address
dataIn  output  XLEN  registered register-file write data
busy_mask  output  NREG  pending-write bitmap (bit 0 always 0)

Behaviour:
- Reset (asynchronous, nReset low): pending = 0, hold buffer empty, long_busy = 0, writeRegMem = 0, rd = 0, dataIn = 0. Reset mid-operation discards all in-flight entries.
- Hazard stall, combinational: issue_stall = issue_valid && (RAW1 || RAW2 || WAW || LONG).
  - RAW1 = issue_uses_rs1 && pending[issue_rs1]
  - RAW2 = issue_uses_rs2 && pending[issue_rs2]
  - WAW = issue_rd != 0 && pending[issue_rd]
  - LONG = issue_long && long_busy
  - pending[0] is hard-wired 0, so x0 never stalls.
- Accepted issue (issue_valid && !issue_stall):
  - if issue_rd != 0, set pending[issue_rd] at the next edge;
  - if issue_long, set long_busy.
- long_busy clears on an LSU handshake (lsu_valid && lsu_ready). At most one long op is outstanding.
- Hold buffer: one entry (hold_valid, hold_rd, hold_data) for ALU results that lose arbitration.
- lsu_ready = !hold_valid.
- Arbitration, per cycle, one winner registered into writeRegMem/rd/dataIn at the edge:
  1. hold_valid: write the hold entry. An incoming ALU result (if alu_valid) refills the hold buffer at the same edge. The LSU waits.
  2. else lsu_valid: write the LSU result. An incoming ALU result goes into the hold buffer.
  3. else alu_valid: write the ALU result.
  4. else writeRegMem = 0; rd and dataIn keep their previous values.
- The hold buffer never overflows: it drains every cycle it is full, and at most one ALU result arrives per cycle.
- Winner with rd == 0: writeRegMem registers 0 (x0 is never written). The handshake and long_busy clear still take effect.
- Latency: a producer result that wins in cycle N has writeRegMem high in cycle N+1; the register file stores it at the end of N+1.
- pending[r] clears at the edge ending a cycle in which writeRegMem && rd == r. Consumers of r stall through that cycle and issue the following cycle, reading the stored value.
- Same-register set and clear at one edge cannot occur, because WAW stalls the issue. The scoreboard still gives clear priority over set.
- busy_mask = pending, registered.

Test Plan:
- Reset with nReset=0 mid-stream (hold_valid=1, pending=0x0000_0F00) → all outputs 0, busy_mask=0, lsu_ready=1; first post-reset issue with no hazard → issue_stall=0.
- Issue rd=5; one cycle later alu_valid rd=5 data=0x1234 → writeRegMem=1, rd=5, dataIn=0x1234 next cycle; issue rs1=5 stalls that cycle and is accepted the cycle after; busy_mask bit5: 1→0.
- Same cycle: lsu_valid rd=7 data=0xAAAA and alu_valid rd=3 data=0x5555 → cycle+1 writes x7=0xAAAA; cycle+2 writes x3=0x5555 (from hold); lsu_ready=0 during cycle+1.
- Back-to-back alu_valid for 4 cycles while lsu_valid is held → ALU results written in order with no loss; LSU result written once an idle cycle lets the hold buffer drain.
- Issue long rd=9, then a second long issue → issue_stall=1 until the LSU handshake; WAW issue rd=9 stalls until x9 is written.
- alu_valid rd=0 data=0xFFFF_FFFF → writeRegMem stays 0; busy_mask bit0 stays 0.
